// File: rtl/microseq_pkg.sv
// ----------------------------------------------------------------------------
// microseq_pkg
// Shared definitions for the microcode address sequencer:
//   - seq_op_t   : sequencing operation decoded from the current microword
//   - DEF_*      : default geometry and vector addresses used as parameter
//                  defaults by microcode_sequencer and microseq_stack
//   - min1_clog2 : index width helper that never returns zero
// Optional feature macro used by the sequencer: MICROSEQ_STACK_CHECK_EN.
// ----------------------------------------------------------------------------
package microseq_pkg;

    typedef enum logic [2:0] {
        NEXT     = 3'd0,
        JUMP     = 3'd1,
        COND     = 3'd2,
        CALL     = 3'd3,
        RET      = 3'd4,
        DISPATCH = 3'd5,
        RESTART  = 3'd6
    } seq_op_t;

    localparam int unsigned DEF_ADDR_W      = 32'd11;
    localparam int unsigned DEF_STACK_DEPTH = 32'd4;
    localparam int unsigned DEF_NUM_COND    = 32'd16;
    localparam int unsigned DEF_NUM_EVT     = 32'd4;
    localparam int unsigned DEF_DISPATCH_W  = 32'd8;

    localparam logic [10:0] DEF_RESET_ADDR = 11'h129;
    localparam logic [10:0] DEF_FAULT_ADDR = 11'h12f;
    localparam logic [10:0] DEF_EVT_BASE   = 11'h12a;

    // Width of an index into a vector of n entries; at least one bit so that
    // single-entry configurations still get a legal signal declaration.
    function automatic int unsigned min1_clog2(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        if (n > 32'd2) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// ----------------------------------------------------------------------------
// microseq_stack
// Return-address LIFO for microcode subroutine calls.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (empties the stack)
//   push, pop      : push alone appends; push with pop replaces the top entry;
//                    pop alone removes the top entry
//   clear          : empties the stack, wins over push/pop
//   push_data      : value written by push
//   top            : current top entry (zero when empty)
//   depth          : number of occupied entries
//   full, empty    : depth == DEPTH / depth == 0
// A push while full overwrites the top entry so the pointer never runs past
// the storage; a pop while empty is ignored.
// ----------------------------------------------------------------------------
module microseq_stack
    import microseq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 32'd1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  depth_q;
    logic [PTR_W-1:0]  depth_d;
    logic [ADDR_W-1:0] top_s;

    assign full  = (depth_q == PTR_W'(DEPTH));
    assign empty = (depth_q == {PTR_W{1'b0}});
    assign depth = depth_q;
    assign top   = top_s;

    // Top-of-stack read: entry at index depth-1, zero when empty.
    always_comb begin
        top_s = {ADDR_W{1'b0}};
        for (int i = 0; i < int'(DEPTH); i++) begin
            top_s = (depth_q == PTR_W'(i + 1)) ? mem_q[i] : top_s;
        end
    end

    // Next-state for pointer and storage.
    always_comb begin
        depth_d = depth_q;
        mem_d   = mem_q;
        if (clear) begin
            depth_d = {PTR_W{1'b0}};
        end else if (push && (pop || full)) begin
            // replace the current top entry; nothing to replace when empty
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (depth_q == PTR_W'(i + 1)) begin
                    mem_d[i] = push_data;
                end else begin
                    mem_d[i] = mem_q[i];
                end
            end
        end else if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (depth_q == PTR_W'(i)) begin
                    mem_d[i] = push_data;
                end else begin
                    mem_d[i] = mem_q[i];
                end
            end
            depth_d = depth_q + PTR_W'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - PTR_W'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= {PTR_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// ----------------------------------------------------------------------------
// microcode_sequencer
// Computes the next microcode address every cycle and holds the current one.
// next_addr drives a synchronous microcode ROM, so the microword for addr is
// available in the same cycle as addr.
// Ports:
//   clk, reset_n      : core clock, asynchronous active-low reset
//   stall             : hold addr, suppress every side effect
//   seq_op/seq_target : sequencing operation and target from the microword
//   cond_sel/cond_invert/cond : condition select for COND
//   dispatch_valid/dispatch_addr/dispatch_rd : opcode dispatch handshake
//   yield/evt_req/evt_ack : prioritised event vectoring (bit 0 highest)
//   addr              : registered current address
//   next_addr         : combinational ROM read address
//   stack_depth       : occupied call-stack entries
//   stack_fault       : sticky stack overflow/underflow flag
// Optional feature: define MICROSEQ_STACK_CHECK_EN to vector stack
// overflow/underflow to FAULT_ADDR and flag it; otherwise a full CALL
// overwrites the top entry and an empty RET restarts at RESET_ADDR.
// ----------------------------------------------------------------------------
module microcode_sequencer
    import microseq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter int unsigned       STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int unsigned       NUM_COND    = DEF_NUM_COND,
    parameter int unsigned       NUM_EVT     = DEF_NUM_EVT,
    parameter int unsigned       DISPATCH_W  = DEF_DISPATCH_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(DEF_RESET_ADDR),
    parameter logic [ADDR_W-1:0] FAULT_ADDR  = ADDR_W'(DEF_FAULT_ADDR),
    parameter logic [ADDR_W-1:0] EVT_BASE    = ADDR_W'(DEF_EVT_BASE)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             stall,
    input  logic [2:0]                       seq_op,
    input  logic [ADDR_W-1:0]                seq_target,
    input  logic [$clog2(NUM_COND)-1:0]      cond_sel,
    input  logic                             cond_invert,
    input  logic [NUM_COND-1:0]              cond,
    input  logic                             dispatch_valid,
    input  logic [DISPATCH_W-1:0]            dispatch_addr,
    output logic                             dispatch_rd,
    input  logic                             yield,
    input  logic [NUM_EVT-1:0]               evt_req,
    output logic [NUM_EVT-1:0]               evt_ack,
    output logic [ADDR_W-1:0]                addr,
    output logic [ADDR_W-1:0]                next_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
    output logic                             stack_fault
);

    localparam int unsigned EVT_IDX_W = min1_clog2(NUM_EVT);

    seq_op_t               op_s;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W-1:0]     addr_d;
    logic                  stack_fault_q;
    logic                  stack_fault_d;
    logic [ADDR_W-1:0]     addr_inc_s;
    logic [EVT_IDX_W-1:0]  evt_idx_s;
    logic [NUM_EVT-1:0]    evt_oh_s;
    logic                  evt_take_s;
    logic                  cond_hit_s;
    logic                  fault_s;
    logic                  set_fault_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  clear_s;
    logic                  rd_s;
    logic [NUM_EVT-1:0]    ack_s;
    logic [ADDR_W-1:0]     nxt_s;
    logic [ADDR_W-1:0]     stk_top_s;
    logic                  stk_full_s;
    logic                  stk_empty_s;

    assign op_s       = seq_op_t'(seq_op);
    assign addr_inc_s = addr_q + ADDR_W'(1);
    assign evt_take_s = yield && (|evt_req);
    assign cond_hit_s = cond[cond_sel] ^ cond_invert;

    // Lowest-numbered pending event wins; scan from the top so bit 0 lands last.
    always_comb begin
        evt_idx_s = {EVT_IDX_W{1'b0}};
        evt_oh_s  = {NUM_EVT{1'b0}};
        for (int i = int'(NUM_EVT) - 1; i >= 0; i--) begin
            evt_idx_s = evt_req[i] ? EVT_IDX_W'(i) : evt_idx_s;
            evt_oh_s  = evt_req[i] ? (NUM_EVT'(1) << i) : evt_oh_s;
        end
    end

    // Stack misuse detection; only acted on in the checked build.
    always_comb begin
`ifdef MICROSEQ_STACK_CHECK_EN
        fault_s = ((op_s == CALL) && stk_full_s) || ((op_s == RET) && stk_empty_s);
`else
        fault_s = 1'b0;
`endif
    end

    // Next-address priority mux and side-effect strobes.
    always_comb begin
        nxt_s       = addr_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clear_s     = 1'b0;
        rd_s        = 1'b0;
        ack_s       = {NUM_EVT{1'b0}};
        set_fault_s = 1'b0;
        if (!reset_n) begin
            nxt_s = RESET_ADDR;
        end else if (stall) begin
            nxt_s = addr_q;
        end else if (evt_take_s) begin
            nxt_s = EVT_BASE + ADDR_W'(evt_idx_s);
            ack_s = evt_oh_s;
        end else if (fault_s) begin
            nxt_s       = FAULT_ADDR;
            clear_s     = 1'b1;
            set_fault_s = 1'b1;
        end else begin
            case (op_s)
                NEXT: begin
                    nxt_s = addr_inc_s;
                end
                JUMP: begin
                    nxt_s = seq_target;
                end
                COND: begin
                    nxt_s = cond_hit_s ? seq_target : addr_inc_s;
                end
                CALL: begin
                    // a full stack replaces its top entry instead of growing
                    push_s = 1'b1;
                    pop_s  = stk_full_s;
                    nxt_s  = seq_target;
                end
                RET: begin
                    if (stk_empty_s) begin
                        nxt_s = RESET_ADDR;
                    end else begin
                        pop_s = 1'b1;
                        nxt_s = stk_top_s;
                    end
                end
                DISPATCH: begin
                    if (dispatch_valid) begin
                        nxt_s = ADDR_W'(dispatch_addr);
                        rd_s  = 1'b1;
                    end else begin
                        nxt_s = addr_q;
                    end
                end
                RESTART: begin
                    nxt_s   = RESET_ADDR;
                    clear_s = 1'b1;
                end
                default: begin
                    nxt_s = addr_inc_s;
                end
            endcase
        end
    end

    assign addr_d        = nxt_s;
    assign stack_fault_d = stack_fault_q | set_fault_s;

    // Current address and sticky fault flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= RESET_ADDR;
            stack_fault_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            stack_fault_q <= stack_fault_d;
        end
    end

    microseq_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .clear     (clear_s),
        .push_data (addr_inc_s),
        .top       (stk_top_s),
        .depth     (stack_depth),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    assign addr        = addr_q;
    assign next_addr   = nxt_s;
    assign evt_ack     = ack_s;
    assign dispatch_rd = rd_s;
    assign stack_fault = stack_fault_q;

endmodule
